// File: rtl/fir_pkg.sv
// Shared types for the multi-channel FIR stream wrapper.
// Optional feature macro: FIR_BYPASS_EN (see fir_mc_stream_top).
package fir_pkg;

    localparam int SAMPLE_W = 16;
    localparam int CH_DEF   = 2;

    // Channel index width, kept at least 1 bit so CH=1 still has a port.
    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CHW = chw(CH_DEF);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef struct packed {
        logic [CHW-1:0] chan;
        sample_t        data;
    } tag_entry_t;

endpackage

// File: rtl/fir_tag_fifo.sv
// Synchronous first-word-fall-through FIFO holding channel-tagged results.
// Head data reads as zero while empty so the output port has a clean value.
module fir_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = empty ? '0 : mem[rd_ptr];

    // Storage array; no reset needed since empty masks the head.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_mc_stream_top.sv
// Multi-channel stream wrapper sequencing frames through one shared FIR core.
// Define FIR_BYPASS_EN to add a bypass input that skips the core per channel.
module fir_mc_stream_top
    import fir_pkg::*;
#(
    parameter int DW      = 16,
    parameter int CH      = 2,
    parameter int FIFO_D  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef FIR_BYPASS_EN
    input  logic                  bypass,
`endif
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CH*DW-1:0]      s_data,
    output logic [DW-1:0]         core_x,
    output logic [chw(CH)-1:0]    core_ch,
    output logic                  core_start,
    input  logic [DW-1:0]         core_y,
    input  logic                  core_done,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DW-1:0]         m_data,
    output logic [chw(CH)-1:0]    m_chan,
    output logic                  fault
);

    localparam int CW  = chw(CH);
    localparam int EW  = CW + DW;
    localparam int AW  = $clog2(FIFO_D);
    localparam int WDW = $clog2(TIMEOUT) + 1;

    localparam logic [CW-1:0]  CH_LAST = CW'(CH - 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_t            state;
    logic [CW-1:0]     ch;
    logic [CH*DW-1:0]  frame;
    logic [WDW-1:0]    wd;
    logic              drain;

    logic              byp;
    logic              last;
    logic              timeout;
    logic [DW-1:0]     cur_x;

    logic              push;
    logic [EW-1:0]     push_entry;
    logic              pop;
    logic [EW-1:0]     head;
    logic              full;
    logic              empty;
    logic [AW:0]       count;

`ifdef FIR_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    assign last    = (ch == CH_LAST);
    assign timeout = (wd == WD_LAST);
    assign cur_x   = frame[ch*DW +: DW];

    // Select the FIFO write source: bypass sample, core result or timeout zero.
    always_comb begin
        push       = 1'b0;
        push_entry = {ch, {DW{1'b0}}};
        if (state == ISSUE && byp && !full) begin
            push       = 1'b1;
            push_entry = {ch, cur_x};
        end else if (state == WAIT && core_done) begin
            push       = 1'b1;
            push_entry = {ch, core_y};
        end else if (state == WAIT && timeout) begin
            push       = 1'b1;
        end
    end

    assign pop     = m_valid && m_ready;
    assign m_valid = !empty;
    assign {m_chan, m_data} = head;

    fir_tag_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Sequencer: latch frame, issue each channel, await result or timeout.
    // drain masks a late core_done from a frame that reset just discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            s_ready    <= 1'b0;
            ch         <= '0;
            frame      <= '0;
            wd         <= '0;
            drain      <= 1'b1;
            core_start <= 1'b0;
            core_x     <= '0;
            core_ch    <= '0;
            fault      <= 1'b0;
        end else begin
            drain      <= 1'b0;
            core_start <= 1'b0;
            if (core_done && state != WAIT && !drain) begin
                fault <= 1'b1;
            end
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        frame   <= s_data;
                        ch      <= '0;
                        s_ready <= 1'b0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!full) begin
                        if (byp) begin
                            if (last) begin
                                state   <= IDLE;
                                s_ready <= 1'b1;
                            end else begin
                                ch <= ch + 1'b1;
                            end
                        end else begin
                            core_x     <= cur_x;
                            core_ch    <= ch;
                            core_start <= 1'b1;
                            wd         <= '0;
                            state      <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (core_done || timeout) begin
                        if (!core_done) begin
                            fault <= 1'b1;
                        end
                        if (last) begin
                            state   <= IDLE;
                            s_ready <= 1'b1;
                        end else begin
                            ch    <= ch + 1'b1;
                            state <= ISSUE;
                        end
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
